// File: rtl/pwm_nch_if.sv
// pwm_nch_if: register-bus strobes decoded by the peripheral register block
// and consumed by pwm_nch (compare/counter writes and interrupt clears).
interface pwm_nch_if #(
    parameter int unsigned p_num_channels = 4,
    parameter int unsigned p_cmp_width    = 16
);
    logic [p_num_channels-1:0] i_cmp_we;
    logic [p_cmp_width-1:0]    i_cmp_wdata;
    logic                      i_cnt_we;
    logic [p_cmp_width+14:0]   i_cnt_wdata;
    logic [p_num_channels-1:0] i_ip_clr;

    // Register block side: drives the strobes
    modport master (
        output i_cmp_we,
        output i_cmp_wdata,
        output i_cnt_we,
        output i_cnt_wdata,
        output i_ip_clr
    );

    // PWM engine side: consumes the strobes
    modport slave (
        input i_cmp_we,
        input i_cmp_wdata,
        input i_cnt_we,
        input i_cnt_wdata,
        input i_ip_clr
    );
endinterface

// File: rtl/pwm_nch.sv
// pwm_nch: N-channel PWM engine. One shared scaled counter feeds per-channel
// comparators with complement, gang, deglitch and interrupt-pending logic.
// Compare values are shadow-buffered and applied at a period boundary.
// Optional feature: define PWM_CENTER_ALIGN_EN to build the centre-aligned
// comparator selected per channel by i_center; otherwise i_center is ignored.
module pwm_nch #(
    parameter int unsigned p_num_channels = 4,
    parameter int unsigned p_cmp_width    = 16
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic                                  i_en_always,
    input  logic                                  i_en_oneshot,
    input  logic                                  i_zero_cmp,
    input  logic                                  i_sticky,
    input  logic                                  i_deglitch,
    input  logic [3:0]                            i_scale,
    input  logic [p_num_channels-1:0]             i_center,
    input  logic [p_num_channels-1:0]             i_complement,
    input  logic [p_num_channels-1:0]             i_gang,
    pwm_nch_if.slave                              bus,
    output logic [p_num_channels-1:0]             o_pwm,
    output logic [p_num_channels-1:0]             o_ip,
    output logic [p_cmp_width+14:0]               o_counter,
    output logic [p_cmp_width-1:0]                o_scaled,
    output logic [p_num_channels*p_cmp_width-1:0] o_cmp,
    output logic                                  o_running
);
    localparam int unsigned N  = p_num_channels;
    localparam int unsigned W  = p_cmp_width;
    localparam int unsigned CW = p_cmp_width + 15;

    // State registers
    logic [CW-1:0]       cnt_q;
    logic                os_q;
    logic                running_q;
    logic [N-1:0][W-1:0] shadow_q;
    logic [N-1:0][W-1:0] cmp_q;
    logic [N-1:0]        latch_q;
    logic [N-1:0]        hit_q;
    logic [N-1:0]        ip_q;
    logic [N-1:0]        pwm_q;

    // Next-state values
    logic [CW-1:0]       cnt_d;
    logic                os_d;
    logic [N-1:0][W-1:0] shadow_d;
    logic [N-1:0][W-1:0] cmp_d;
    logic [N-1:0]        latch_d;
    logic [N-1:0]        hit_d;
    logic [N-1:0]        ip_d;
    logic [N-1:0]        pwm_d;

    // Combinational helpers
    logic                run_c;
    logic [W-1:0]        scaled_c;
    logic [CW-1:0]       low_mask_c;
    logic                wrap_c;
    logic                pe_c;
    logic [N-1:0]        raw_c;
    logic [N-1:0]        match_c;
    logic [N-1:0]        next_match_c;
    logic [N-1:0]        gate_c;
    logic [N-1:0]        first_c;

    // Run state and scaled view of the raw counter; scale applies live
    always_comb begin
        run_c      = i_en_always | os_q;
        scaled_c   = W'(cnt_q >> i_scale);
        low_mask_c = (CW'(1) << i_scale) - CW'(1);
        wrap_c     = (&scaled_c) & ((cnt_q & low_mask_c) == low_mask_c);
    end

`ifdef PWM_CENTER_ALIGN_EN
    logic [W-1:0] flip_c;
    logic [W-1:0] fold_c;

    // Triangle fold: distance from the nearer period end, doubled to full range
    always_comb begin
        flip_c = scaled_c ^ {W{scaled_c[W-1]}};
        fold_c = flip_c << 1;
    end

    // Raw compare per channel, edge or centre as selected
    always_comb begin
        raw_c = '0;
        for (int unsigned x = 0; x < N; x++) begin
            raw_c[x] = i_center[x] ? (fold_c >= cmp_q[x]) : (scaled_c >= cmp_q[x]);
        end
    end
`else
    logic unused_center;
    assign unused_center = ^i_center;

    // Raw compare per channel, edge-aligned only
    always_comb begin
        raw_c = '0;
        for (int unsigned x = 0; x < N; x++) begin
            raw_c[x] = (scaled_c >= cmp_q[x]);
        end
    end
`endif

    // Period end, deglitched match, gang masking and first-match detect
    always_comb begin
        pe_c         = run_c & (wrap_c | (i_zero_cmp & raw_c[0]));
        match_c      = raw_c | ({N{i_deglitch}} & latch_q);
        // rotate so bit x holds the match of channel (x+1) mod N
        next_match_c = (match_c >> 1) | (match_c << (N - 1));
        gate_c       = match_c & ~(i_gang & next_match_c);
        first_c      = {N{run_c}} & match_c & ~hit_q;
    end

    // Next-state logic for counter, one-shot, compares and per-channel flags
    always_comb begin
        cnt_d    = cnt_q;
        os_d     = os_q;
        shadow_d = shadow_q;
        cmp_d    = cmp_q;
        latch_d  = '0;
        hit_d    = hit_q;
        ip_d     = ip_q;
        pwm_d    = '0;

        // software write beats period reset, which beats increment
        if (bus.i_cnt_we) begin
            cnt_d = bus.i_cnt_wdata;
        end else if (pe_c) begin
            cnt_d = '0;
        end else if (run_c) begin
            cnt_d = cnt_q + CW'(1);
        end

        if (i_en_oneshot && (pe_c || !run_c)) begin
            os_d = 1'b1;
        end else if (pe_c) begin
            os_d = 1'b0;
        end

        // a write landing on the load cycle is forwarded straight to active
        for (int unsigned x = 0; x < N; x++) begin
            if (bus.i_cmp_we[x]) begin
                shadow_d[x] = bus.i_cmp_wdata;
            end
            if (pe_c || !run_c) begin
                cmp_d[x] = shadow_d[x];
            end
        end

        latch_d = {N{i_deglitch & ~pe_c}} & match_c;
        hit_d   = pe_c ? '0 : (hit_q | ({N{run_c}} & match_c));
        ip_d    = first_c | (ip_q & ~(bus.i_ip_clr & {N{~i_sticky}}));
        pwm_d   = gate_c ^ i_complement;
    end

    // State register with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q     <= '0;
            os_q      <= 1'b0;
            running_q <= 1'b0;
            shadow_q  <= '0;
            cmp_q     <= '0;
            latch_q   <= '0;
            hit_q     <= '0;
            ip_q      <= '0;
            pwm_q     <= '0;
        end else begin
            cnt_q     <= cnt_d;
            os_q      <= os_d;
            running_q <= run_c;
            shadow_q  <= shadow_d;
            cmp_q     <= cmp_d;
            latch_q   <= latch_d;
            hit_q     <= hit_d;
            ip_q      <= ip_d;
            pwm_q     <= pwm_d;
        end
    end

    assign o_pwm     = pwm_q;
    assign o_ip      = ip_q;
    assign o_counter = cnt_q;
    assign o_scaled  = scaled_c;
    assign o_cmp     = cmp_q;
    assign o_running = running_q;

endmodule
